// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB master arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage : apb_pkg

// File: rtl/apb_master_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Combinational grant: last=1 means requester 1 was served most recently.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule : rr_arb2

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters; one transfer at a time, round-robin grant,
// ACCESS-phase timeout reported as an error on the requester's done pulse.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  rw0,
    input  logic                  rw1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  apb_psel,
    output logic                  apb_enab,
    output logic                  apb_rw,
    output logic [ADDR_WIDTH-1:0] apb_addr,
    output logic [DATA_WIDTH-1:0] apb_datai,
    input  logic [DATA_WIDTH-1:0] apb_datao,
    input  logic                  apb_ack
);

    // Counter value in the last ACCESS cycle before the timeout fires.
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [1:0] grant;
    logic       last;
    logic       gidx;
    logic [7:0] tcnt;
    logic       acc_end;
    logic       acc_err;

    rr_arb2 u_arb (
        .req   ({req1, req0}),
        .last  (last),
        .grant (grant)
    );

    // ACCESS ends on ack or on the final allowed cycle; ack on that cycle wins.
    always_comb begin
        acc_end = 1'b0;
        acc_err = 1'b0;
        if (state == ST_ACCESS) begin
            acc_end = apb_ack || (tcnt == TIMEOUT_LIMIT);
            acc_err = !apb_ack;
        end
    end

    // Transfer sequencer with all bus and requester outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            gidx      <= 1'b0;
            tcnt      <= '0;
            apb_psel  <= 1'b0;
            apb_enab  <= 1'b0;
            apb_rw    <= 1'b0;
            apb_addr  <= '0;
            apb_datai <= '0;
            rdata     <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    if (|grant) begin
                        gidx      <= grant[1];
                        last      <= grant[1];
                        apb_rw    <= grant[1] ? rw1    : rw0;
                        apb_addr  <= grant[1] ? addr1  : addr0;
                        apb_datai <= grant[1] ? wdata1 : wdata0;
                        apb_psel  <= 1'b1;
                        apb_enab  <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    apb_enab <= 1'b1;
                    tcnt     <= '0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (acc_end) begin
                        apb_psel <= 1'b0;
                        apb_enab <= 1'b0;
                        rdata    <= (acc_err || apb_rw) ? '0 : apb_datao;
                        done0    <= !gidx;
                        done1    <= gidx;
                        err0     <= !gidx && acc_err;
                        err1     <= gidx && acc_err;
                        state    <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : apb_master_arbiter

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (TIMEOUT=4).
module tb_apb_master_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        rw0 = 1'b0, rw1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata;
    logic        apb_psel, apb_enab, apb_rw;
    logic [31:0] apb_addr, apb_datai;
    logic [31:0] apb_datao = '0;
    logic        apb_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int n_access;

    apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
        .apb_psel(apb_psel), .apb_enab(apb_enab), .apb_rw(apb_rw),
        .apb_addr(apb_addr), .apb_datai(apb_datai),
        .apb_datao(apb_datao), .apb_ack(apb_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".psel"},  32'(apb_psel), 32'h0);
        chk({tag, ".enab"},  32'(apb_enab), 32'h0);
        chk({tag, ".rw"},    32'(apb_rw),   32'h0);
        chk({tag, ".addr"},  apb_addr,      32'h0);
        chk({tag, ".datai"}, apb_datai,     32'h0);
        chk({tag, ".rdata"}, rdata,         32'h0);
        chk({tag, ".done"},  {30'h0, done1, done0}, 32'h0);
        chk({tag, ".err"},   {30'h0, err1, err0},   32'h0);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_all_zero("reset");

        // Write from requester 0, ack in first ACCESS cycle
        req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hA5A5_0001;
        apb_datao = 32'h7777_7777;
        tick();
        chk("wr.setup.pe", {30'h0, apb_psel, apb_enab}, 32'h2);
        chk("wr.setup.rw", 32'(apb_rw), 32'h1);
        chk("wr.setup.addr", apb_addr, 32'h8);
        chk("wr.setup.datai", apb_datai, 32'hA5A5_0001);
        addr0 = 32'hFFFF_0000; wdata0 = 32'h0;
        tick();
        chk("wr.access.pe", {30'h0, apb_psel, apb_enab}, 32'h3);
        chk("wr.access.addr_hold", apb_addr, 32'h8);
        apb_ack = 1'b1;
        tick();
        chk("wr.done.pe", {30'h0, apb_psel, apb_enab}, 32'h0);
        chk("wr.done", {30'h0, done1, done0}, 32'h1);
        chk("wr.err", {30'h0, err1, err0}, 32'h0);
        chk("wr.rdata", rdata, 32'h0);
        chk("wr.done.datai_hold", apb_datai, 32'hA5A5_0001);
        req0 = 1'b0; apb_ack = 1'b0;
        tick();
        chk("wr.idle.done", {30'h0, done1, done0}, 32'h0);

        // Read from requester 1, ack after 3 ACCESS cycles
        req1 = 1'b1; rw1 = 1'b0; addr1 = 32'h4; apb_datao = 32'h1234_5678;
        tick();
        chk("rd.setup.addr", apb_addr, 32'h4);
        chk("rd.setup.rw", 32'(apb_rw), 32'h0);
        tick();
        tick();
        chk("rd.access2.pe", {30'h0, apb_psel, apb_enab}, 32'h3);
        chk("rd.access2.done", {30'h0, done1, done0}, 32'h0);
        tick();
        apb_ack = 1'b1;
        tick();
        chk("rd.done", {30'h0, done1, done0}, 32'h2);
        chk("rd.err", {30'h0, err1, err0}, 32'h0);
        chk("rd.rdata", rdata, 32'h1234_5678);
        req1 = 1'b0; apb_ack = 1'b0;
        tick();

        // Contention from reset: order must be 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h100;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 32'h200;
        apb_ack = 1'b1; apb_datao = 32'hBBBB_BBBB;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr%0d.addr", i), apb_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            tick();
            tick();
            chk($sformatf("rr%0d.done", i), {30'h0, done1, done0},
                (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("rr%0d.rdata", i), rdata, 32'h0);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0; apb_ack = 1'b0;
        tick();

        // Timeout: ack never comes, exactly 4 ACCESS cycles
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h10; apb_datao = 32'hDEAD_BEEF;
        tick();
        n_access = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (apb_enab) n_access++;
            else break;
        end
        chk("to.access_cycles", 32'(n_access), 32'd4);
        chk("to.done", {30'h0, done1, done0}, 32'h1);
        chk("to.err", {30'h0, err1, err0}, 32'h1);
        chk("to.rdata", rdata, 32'h0);
        req0 = 1'b0;
        tick();

        // Ack on the 4th ACCESS cycle beats the timeout
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h20; apb_datao = 32'hCAFE_F00D;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("edge.access4.pe", {30'h0, apb_psel, apb_enab}, 32'h3);
        apb_ack = 1'b1;
        tick();
        chk("edge.done", {30'h0, done1, done0}, 32'h1);
        chk("edge.err", {30'h0, err1, err0}, 32'h0);
        chk("edge.rdata", rdata, 32'hCAFE_F00D);
        req0 = 1'b0; apb_ack = 1'b0;
        tick();

        // Reset in ACCESS aborts the transfer; requester 1 then completes
        req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h1111_2222;
        tick();
        tick();
        chk("abort.access.pe", {30'h0, apb_psel, apb_enab}, 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0; req0 = 1'b0;
        chk_all_zero("abort");
        req1 = 1'b1; rw1 = 1'b0; addr1 = 32'h44; apb_datao = 32'h55AA_55AA; apb_ack = 1'b1;
        tick();
        chk("abort.nodone", {30'h0, done1, done0}, 32'h0);
        chk("post.setup.pe", {30'h0, apb_psel, apb_enab}, 32'h2);
        chk("post.setup.addr", apb_addr, 32'h44);
        tick();
        tick();
        chk("post.done", {30'h0, done1, done0}, 32'h2);
        chk("post.err", {30'h0, err1, err0}, 32'h0);
        chk("post.rdata", rdata, 32'h55AA_55AA);
        req1 = 1'b0; apb_ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_apb_master_arbiter
